// File: rtl/gamepad_input.sv
//==============================================================================
// Module   : gamepad_input
// Brief    : Gamepad PMOD deserialiser with per-frame button accumulation,
//            malformed-transfer rejection and disconnect detection.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gamepad_input #(
    parameter int STALE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       pmod_latch,
    input  logic       pmod_clk,
    input  logic       pmod_data,
    output logic [9:0] input_data,
    output logic       trigger,
    output logic       pad_present,
    output logic       frame_error
);

    localparam logic [3:0] c_CNT_FULL    = 4'd12;
    localparam logic [3:0] c_CNT_OVERRUN = 4'd13;
    localparam logic [3:0] c_STALE_MAX   = 4'd15;
    localparam logic [3:0] c_STALE_LIMIT = 4'(STALE_FRAMES);

    logic [2:0]  r_latch_sync;
    logic [2:0]  r_clk_sync;
    logic [1:0]  r_data_sync;
    logic        r_latch_rise;
    logic        r_clk_rise;
    logic        r_data_bit;

    logic [11:0] r_shift;
    logic [3:0]  r_bit_cnt;
    logic [9:0]  r_acc;
    logic        r_prev_a;
    logic [3:0]  r_stale_cnt;

    logic [11:0] w_shift_next;
    logic [3:0]  w_cnt_next;
    logic        w_capture;
    logic        w_discard;
    logic        w_a;
    logic [9:0]  w_cap_word;
    logic [3:0]  w_stale_next;

    // Edge pulses are registered so data and clock edges stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch_sync <= '0;
            r_clk_sync   <= '0;
            r_data_sync  <= '0;
            r_latch_rise <= 1'b0;
            r_clk_rise   <= 1'b0;
            r_data_bit   <= 1'b0;
        end else begin
            r_latch_sync <= {r_latch_sync[1:0], pmod_latch};
            r_clk_sync   <= {r_clk_sync[1:0], pmod_clk};
            r_data_sync  <= {r_data_sync[0], pmod_data};
            r_latch_rise <= r_latch_sync[1] & ~r_latch_sync[2];
            r_clk_rise   <= r_clk_sync[1] & ~r_clk_sync[2];
            r_data_bit   <= r_data_sync[1];
        end
    end

    // A same-cycle clock edge is shifted in before the latch count check.
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_bit_cnt;
        if (r_clk_rise) begin
            w_shift_next = {r_shift[10:0], r_data_bit};
            if (r_bit_cnt != c_CNT_OVERRUN) begin
                w_cnt_next = r_bit_cnt + 4'd1;
            end
        end
        w_capture  = r_latch_rise && (w_cnt_next == c_CNT_FULL);
        w_discard  = r_latch_rise && (w_cnt_next != c_CNT_FULL);
        w_a        = w_shift_next[3];
        w_cap_word = {w_a & ~r_prev_a,
                      w_shift_next[4], w_shift_next[5], w_shift_next[6],
                      w_shift_next[7], w_a, w_shift_next[8],
                      w_shift_next[9], w_shift_next[11], w_shift_next[10]};
        w_stale_next = r_stale_cnt;
        if (w_capture) begin
            w_stale_next = 4'd0;
        end else if (frame_tick && (r_stale_cnt != c_STALE_MAX)) begin
            w_stale_next = r_stale_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_acc       <= '0;
            r_prev_a    <= 1'b0;
            r_stale_cnt <= c_STALE_MAX;
            input_data  <= '0;
            trigger     <= 1'b0;
            pad_present <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (r_latch_rise) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= w_cnt_next;
            end

            if (w_capture) begin
                r_prev_a <= w_a;
            end else if (r_stale_cnt >= c_STALE_LIMIT) begin
                r_prev_a <= 1'b0;
            end

            // A capture coinciding with the tick belongs to the closing frame.
            if (frame_tick) begin
                r_acc <= '0;
                if (pad_present) begin
                    input_data <= r_acc | (w_capture ? w_cap_word : 10'd0);
                end else begin
                    input_data <= '0;
                end
            end else if (w_capture) begin
                r_acc <= r_acc | w_cap_word;
            end

            r_stale_cnt <= w_stale_next;
            pad_present <= (w_stale_next < c_STALE_LIMIT);
            trigger     <= frame_tick;
            frame_error <= w_discard;
        end
    end

endmodule

`default_nettype wire

// File: doc/gamepad_input.md
# gamepad_input

Upstream input stage for the player FSM. Deserialises the Gamepad PMOD serial stream (latch/clock/data), accumulates button activity over each video frame, and on every frame tick presents a 10-bit `input_data` word plus a one-cycle `trigger` to player logic. It synchronises the asynchronous PMOD pins, rejects malformed frames, and forces all buttons to zero if the pad goes silent.

## Interface
- `STALE_FRAMES`, 4: frame ticks without a valid capture before buttons are forced to zero (1..15).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame, synchronous to `clk`.
- `pmod_latch`  in  1  async; rising edge ends a 12-bit transfer.
- `pmod_clk`  in  1  async; data sampled on rising edge.
- `pmod_data`  in  1  async serial data, active-high button = 1.
- `input_data`  out  10  [9] attack press edge, [8] right, [7] left, [6] down, [5] up, [4] attack held, [3] start, [2] select, [1] B, [0] Y.
- `trigger`  out  1  one-cycle strobe: `input_data` is valid.
- `pad_present`  out  1  1 while stale counter < `STALE_FRAMES`.
- `frame_error`  out  1  one-cycle pulse when a transfer is discarded.

## Operation
- Sync: each PMOD pin passes through a 2-FF synchroniser; rising edges are detected on the synchronised value. Edge visible 3 `clk` after pin change.
- Shift: on each `pmod_clk` rise, `shift <= {shift[10:0], data}`; `bit_cnt` increments and saturates at 13.
- Wire order, first bit shifted in: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R. X, L and R are ignored.
- Capture on `pmod_latch` rise:
  - `bit_cnt == 12`: the transfer is valid. `buttons <= shift`, `stale_cnt <= 0`, and the value is OR-accumulated into `acc`.
  - Otherwise: the transfer is discarded and `frame_error` pulses.
  - `bit_cnt` and `shift` clear in both cases.
- Accumulator `acc[9:0]`, cleared at each frame close:
  - Bits 8..0: OR of every valid capture in the frame, per the mapping.
  - Bit 9: set if any valid capture has A=1 while the preceding valid capture (`prev_a`, persists across frames) had A=0.
- Frame close, on `frame_tick`:
  - If `pad_present`: `input_data <= acc` merged with the same-cycle capture. Otherwise `input_data <= 0`.
  - `acc` clears.
  - `stale_cnt` increments, saturating at 15, unless a valid capture arrives the same cycle.
- `trigger` is `frame_tick` delayed one cycle, so `input_data` is stable for the whole `trigger` cycle and until the next frame close.
- Disconnect: when `stale_cnt >= STALE_FRAMES`, `pad_present = 0` and `prev_a` clears. A reconnect therefore cannot create a false attack edge, but a held A generates one edge.
- States, reported via `bit_cnt`: IDLE (cnt=0), SHIFTING (1..12), OVERRUN (13, any latch discards).

## Timing
- Reset values: `input_data=0`, `trigger=0`, `frame_error=0`, `pad_present=0`. Internally `stale_cnt=15`, `acc=0`, `shift=0`, `bit_cnt=0`, `prev_a=0`, and synchronisers are 0.
- Latency: pin latch edge to `acc` update is 4 cycles. `frame_tick` to `trigger` is 1 cycle, and `input_data` changes in that same cycle.
- Capture and `frame_tick` in the same cycle: the capture belongs to the closing frame, and `acc` restarts at 0.
- `pmod_clk` and `pmod_latch` edges in the same cycle: the shift happens first, then the count check includes that bit.
- Reset asserted mid-transfer or mid-frame: all state clears. The first transfer after reset is valid only if a full 12 bits follow the reset.
- Back-to-back `frame_tick` pulses: each produces its own `trigger`. `input_data` becomes 0 if no capture arrived.

## Test plan
- Single valid transfer, Up+A, followed by `frame_tick`:
  - 4 cycles after the latch, `acc` contains the capture.
  - In the `trigger` cycle, `input_data = 10'b1000110000`, `pad_present = 1`.
- A held across two frames, each with one valid transfer:
  - Frame 1 gives bit9=1, bit4=1.
  - Frame 2 gives bit9=0, bit4=1.
- Latch after 11 and after 13 clocks:
  - `frame_error` pulses each time and `acc` is unchanged.
  - A following 12-bit transfer is accepted.
- Stale: after one valid capture, 4 ticks with no transfers.
  - `pad_present` drops after the 4th tick, and that `trigger` carries `input_data = 0`.
  - A new valid capture restores `pad_present` at the next latch.
- Capture coincident with `frame_tick`:
  - The Left press appears in that frame's `input_data` (bit7=1).
  - The next frame without transfers reports bit7=0.
- Reset asserted after 6 shifted bits, then a full 12-bit transfer:
  - The transfer is accepted with no `frame_error`.
  - All outputs read 0 during reset.
